// File: rtl/bram_scan_pkg.sv
// Shared types and constants for the BRAM display scanner.
// Holds the scan FSM encoding, the blank pattern and the active-low hex font.
package bram_scan_pkg;

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_HOLD
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
// Ports: nib (4-bit value), blank (force all segments off), seg (7-bit out).
module hex_to_seg7
  import bram_scan_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : HEX_FONT[nib];
  end

endmodule

// File: rtl/bram_display_scanner.sv
// Walks BRAM port A, captures each word and shows a 24-bit half on six digits.
// Ports: clk, reset (sync, active-high), run, step, half_sel, addr_a/q_a
// (BRAM port A), word, addr_disp, valid, hex0..hex5 (active-low segments).
// Optional macro BRAM_SCAN_LZB_EN enables leading-zero blanking.
module bram_display_scanner
  import bram_scan_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 48,
  parameter int LAST_ADDR = 1023,
  parameter int DWELL     = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              half_sel,
  output logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] word,
  output logic [ADDR_W-1:0] addr_disp,
  output logic              valid,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5
);

  localparam int CNT_W = $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_disp_q, addr_disp_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              step_q, step_d;
  logic              step_edge;
  logic              expire;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_d      = word_q;
    addr_disp_d = addr_disp_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    step_d      = step;
    step_edge   = step & ~step_q;
    expire      = run && (cnt_q == CNT_LAST);
    unique case (state_q)
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_CAPTURE;
      S_CAPTURE: begin
        word_d      = q_a;
        addr_disp_d = addr_q;
        valid_d     = 1'b1;
        cnt_d       = '0;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        // Expiry and step together still give one advance.
        if (expire || step_edge) begin
          addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
          state_d = S_ISSUE;
        end else if (run) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_ISSUE;
      addr_q      <= '0;
      word_q      <= '0;
      addr_disp_q <= '0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      addr_disp_q <= addr_disp_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
    end
  end

  assign addr_a    = addr_q;
  assign word      = word_q;
  assign addr_disp = addr_disp_q;
  assign valid     = valid_q;

  logic [23:0]      half;
  logic [5:0]       blank;
  logic [5:0][6:0]  seg;

  assign half = half_sel ? word_q[47:24] : word_q[23:0];

  always_comb begin
    blank = {6{~valid_q}};
`ifdef BRAM_SCAN_LZB_EN
    // Digit k is blank when it and every digit above it are zero.
    for (int k = 1; k < 6; k++) begin
      if ((half >> (4 * k)) == 24'd0) blank[k] = 1'b1;
    end
`endif
  end

  for (genvar k = 0; k < 6; k++) begin : g_dig
    hex_to_seg7 u_seg (
      .nib   (half[4*k +: 4]),
      .blank (blank[k]),
      .seg   (seg[k])
    );
  end

  assign hex0 = seg[0];
  assign hex1 = seg[1];
  assign hex2 = seg[2];
  assign hex3 = seg[3];
  assign hex4 = seg[4];
  assign hex5 = seg[5];

endmodule

// File: doc/bram_display_scanner.md
# bram_display_scanner

Read-side consumer for the dual-port block RAM datapath: walks BRAM port A through the address space, captures each 48-bit word, and drives six active-low seven-segment digits with a selectable 24-bit half of the captured word. Addresses advance automatically after a programmable dwell time, or one at a time on a step pulse. It takes the place of the single-digit combinational decoder on `q_a`, giving a board-level memory viewer.

## Interface
- `ADDR_W`, 10, BRAM address width
- `DATA_W`, 48, BRAM word width; must be 48
- `LAST_ADDR`, 1023, highest address scanned before wrap to 0
- `DWELL`, 50_000_000, clock cycles each word is held in auto mode; must be ≥ 2

- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high
- `run` in 1: level; 1 = auto-advance after `DWELL` cycles
- `step` in 1: level from a debounced button; a rising edge requests one advance
- `half_sel` in 1: 0 = display `word[23:0]`, 1 = display `word[47:24]`
- `addr_a` out `ADDR_W`: registered BRAM port A address
- `q_a` in `DATA_W`: BRAM port A read data, valid one clock after `addr_a`
- `word` out `DATA_W`: last captured word
- `addr_disp` out `ADDR_W`: address that `word` came from
- `valid` out 1: 1 once at least one word has been captured since reset
- `hex0`..`hex5` out 7 each: active-low segments {g,f,e,d,c,b,a}; `hex0` = least significant nibble

## Operation
- States: ISSUE, WAIT, CAPTURE, HOLD.
- ISSUE: `addr_a` holds the current address → WAIT.
- WAIT: BRAM registers the read → CAPTURE.
- CAPTURE: `word` ← `q_a`; `addr_disp` ← `addr_a`; `valid` ← 1; dwell counter ← 0 → HOLD.
- HOLD: dwell counter increments while `run`=1 and freezes while `run`=0. Advance when the counter reaches `DWELL`-1 with `run`=1, or on a step edge.
- Advance: `addr_a` ← (`addr_a`==`LAST_ADDR`) ? 0 : `addr_a`+1 → ISSUE.
- Step-edge detect: register `step`; edge = `step` & ~`step_q`. Edges outside HOLD are dropped, not queued.
- Step edge and dwell expiry in the same cycle cause one advance only.
- Port A is read-only from this block; no write-enable is driven.
- Digits: nibble *k* of the selected half → `hex`*k*, through the 16-entry hex font (0–9, A–F; digit 8 = 7'b0000000). `half_sel` is combinational into the digit mux and takes effect immediately.
- `valid`=0: all digits blank (7'b1111111).

## Timing
- Reset values: state ISSUE; `addr_a`=0; `word`=0; `addr_disp`=0; `valid`=0; dwell counter 0; `step_q`=0; all `hex*`=7'b1111111.
- First capture: `word`/`valid` update on the 3rd rising edge after `reset` is released (ISSUE, WAIT, CAPTURE).
- Advance to new word visible: 3 clocks (ISSUE, WAIT, CAPTURE).
- Auto period per word: `DWELL` + 3 clocks.
- Reset asserted in any state, including mid-read, aborts the read and restores reset values the next edge. No partial capture is allowed.
- Wrap: after `LAST_ADDR` the next address is 0, with no extra cycle.

## Configuration
- `BRAM_SCAN_LZB_EN` defined: leading-zero blanking. In the selected half, zero digits above the highest non-zero digit are blanked; `hex0` always shows its value (0 shows "0").
- Not defined: all six digits always shown.

## Structure
- Shared package `bram_scan_pkg`:
  - state encoding (2-bit enum)
  - `SEG_BLANK` = 7'h7F
  - 16-entry active-low hex font constant
- Sub-module `hex_to_seg7`: combinational 4-bit → 7-bit decoder with a `blank` input, instanced six times.
- FSM, counters and capture registers live in the top module.

## Test plan
- Reset, then BRAM preloaded with mem[0]=48'h0123_4567_89AB, `half_sel`=0, `run`=0 → by the 3rd edge: `valid`=1, `addr_disp`=0, digits hex5..hex0 show 6,7,8,9,A,B. Set `half_sel`=1 → 0,1,2,3,4,5.
- `DWELL`=4, `run`=1, mem[n]=n → `addr_disp` steps 0,1,2… every 7 clocks; `LAST_ADDR`=3 wraps 3→0.
- `run`=0, three step rising edges, one issued during WAIT → exactly two advances (`addr_disp` 0→1→2).
- Step edge on the same cycle as dwell expiry → single advance.
- `reset` pulsed during WAIT at address 5 → next cycle `addr_a`=0, `valid`=0, all digits 7'h7F.
- With `BRAM_SCAN_LZB_EN`: word 48'h0000_0000_00A0, `half_sel`=0 → hex5..hex2 blank, hex1="A", hex0="0"; word 0 → only hex0 shows "0". Without the macro, all six digits shown.
